// File: rtl/tick_scheduler.sv
// Periodic event scheduler: per-channel tick counters raise pending requests,
// and a round-robin arbiter serialises them onto one registered valid/ready port.
module tick_scheduler #(
  parameter int NUM_CH   = 4,
  parameter int PERIOD_W = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_tick,
  input  logic [NUM_CH-1:0]            ch_en,
  input  logic [NUM_CH*PERIOD_W-1:0]   ch_period,
  output logic                         evt_valid,
  output logic [$clog2(NUM_CH)-1:0]    evt_ch,
  input  logic                         evt_ready,
  output logic [NUM_CH-1:0]            overrun,
  input  logic                         overrun_clr
);

  localparam int CH_W = $clog2(NUM_CH);

  logic [PERIOD_W-1:0] cnt_q [NUM_CH];
  logic [PERIOD_W-1:0] cnt_d [NUM_CH];
  logic [NUM_CH-1:0]   pending_q, pending_d;
  logic [NUM_CH-1:0]   overrun_q, overrun_d;
  logic [NUM_CH-1:0]   expire;
  logic [NUM_CH-1:0]   req;
  logic [NUM_CH-1:0]   grant_vec;
  logic                evt_valid_q, evt_valid_d;
  logic [CH_W-1:0]     evt_ch_q, evt_ch_d;
  logic [CH_W-1:0]     last_q, last_d;
  logic                stage_free;
  logic                grant_found;
  logic [CH_W-1:0]     grant_idx;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [PERIOD_W-1:0] period;
    logic [PERIOD_W-1:0] limit;

    assign period = ch_period[k*PERIOD_W +: PERIOD_W];
    // A zero period behaves as one; >= lets a shortened period take effect at once.
    assign limit     = (period == '0) ? '0 : period - PERIOD_W'(1);
    assign expire[k] = ch_en[k] & i_tick & (cnt_q[k] >= limit);

    assign cnt_d[k] = !ch_en[k] ? '0 :
                      !i_tick   ? cnt_q[k] :
                      expire[k] ? '0 : cnt_q[k] + PERIOD_W'(1);

    // A fresh expiry on the channel being granted re-arms pending without an overrun.
    assign pending_d[k] = ch_en[k] & (expire[k] | (pending_q[k] & ~grant_vec[k]));
    assign overrun_d[k] = (expire[k] & pending_q[k] & ~grant_vec[k]) |
                          (overrun_q[k] & ~overrun_clr);
  end

  assign req        = pending_q & ch_en;
  assign stage_free = ~evt_valid_q | evt_ready;

  always_comb begin
    logic [CH_W-1:0] idx;
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = CH_W'((int'(last_q) + i) % NUM_CH);
      if (!grant_found && req[idx]) begin
        grant_found = 1'b1;
        grant_idx   = idx;
      end
    end
  end

  always_comb begin
    grant_vec   = '0;
    evt_valid_d = evt_valid_q;
    evt_ch_d    = evt_ch_q;
    last_d      = last_q;
    if (stage_free) begin
      evt_valid_d = grant_found;
      if (grant_found) begin
        grant_vec[grant_idx] = 1'b1;
        evt_ch_d             = grant_idx;
        last_d               = grant_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_CH; k++) cnt_q[k] <= '0;
      pending_q   <= '0;
      overrun_q   <= '0;
      evt_valid_q <= 1'b0;
      evt_ch_q    <= '0;
      last_q      <= CH_W'(NUM_CH - 1);
    end else begin
      for (int k = 0; k < NUM_CH; k++) cnt_q[k] <= cnt_d[k];
      pending_q   <= pending_d;
      overrun_q   <= overrun_d;
      evt_valid_q <= evt_valid_d;
      evt_ch_q    <= evt_ch_d;
      last_q      <= last_d;
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_ch    = evt_ch_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_tick_scheduler.sv
// Scoreboard bench for tick_scheduler: expected (channel, arrival cycle) pairs are
// queued as ticks are driven and matched against accepted events.
module tb_tick_scheduler;

  localparam int NUM_CH = 4;
  localparam int PW     = 16;

  typedef struct {
    int ch;
    int cyc;
  } exp_t;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               i_tick = 1'b0;
  logic [NUM_CH-1:0]  ch_en = '0;
  logic [NUM_CH*PW-1:0] ch_period = '0;
  logic               evt_valid;
  logic [1:0]         evt_ch;
  logic               evt_ready = 1'b0;
  logic [NUM_CH-1:0]  overrun;
  logic               overrun_clr = 1'b0;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  tick_scheduler #(.NUM_CH(NUM_CH), .PERIOD_W(PW)) dut (
    .clk        (clk),
    .reset      (reset),
    .i_tick     (i_tick),
    .ch_en      (ch_en),
    .ch_period  (ch_period),
    .evt_valid  (evt_valid),
    .evt_ch     (evt_ch),
    .evt_ready  (evt_ready),
    .overrun    (overrun),
    .overrun_clr(overrun_clr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_evt(input int ch, input int dly);
    exp_t e;
    e.ch  = ch;
    e.cyc = cyc + dly;
    exp_q.push_back(e);
  endtask

  task automatic set_period(input int k, input int p);
    ch_period[k*PW +: PW] = p[PW-1:0];
  endtask

  task automatic do_tick();
    i_tick = 1'b1;
    step(1);
    i_tick = 1'b0;
  endtask

  task automatic do_reset();
    ch_en       = '0;
    ch_period   = '0;
    i_tick      = 1'b0;
    evt_ready   = 1'b0;
    overrun_clr = 1'b0;
    reset       = 1'b1;
    step(2);
    reset = 1'b0;
  endtask

  // Accepted events are matched in order against the scoreboard.
  always @(negedge clk) begin
    if (!reset && evt_valid && evt_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_evt", int'(evt_valid), 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_eq("evt_ch", int'(evt_ch), e.ch);
        check_eq("evt_cyc", cyc, e.cyc);
      end
    end
  end

  initial begin
    // Reset state
    step(2);
    check_eq("rst_valid", int'(evt_valid), 0);
    check_eq("rst_ch", int'(evt_ch), 0);
    check_eq("rst_overrun", int'(overrun), 0);

    // Single channel, period 3: fires on ticks 3, 6, 9
    do_reset();
    set_period(0, 3);
    ch_en = 4'b0001;
    evt_ready = 1'b1;
    step(1);
    for (int i = 1; i <= 9; i++) begin
      if (i % 3 == 0) expect_evt(0, 2);
      do_tick();
      step(4);
    end
    step(3);
    check_eq("p3_drain", exp_q.size(), 0);

    // Round-robin on simultaneous expiry, two rounds
    do_reset();
    for (int k = 0; k < NUM_CH; k++) set_period(k, 1);
    ch_en = 4'b1111;
    evt_ready = 1'b1;
    step(1);
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < NUM_CH; c++) expect_evt(c, 2 + c);
      do_tick();
      step(8);
    end
    check_eq("rr_drain", exp_q.size(), 0);

    // Backpressure: held output, merged event, sticky overrun
    do_reset();
    set_period(1, 1);
    ch_en = 4'b0010;
    step(1);
    for (int t = 1; t <= 3; t++) begin
      do_tick();
      step(4);
      check_eq("bp_valid_held", int'(evt_valid), 1);
      check_eq("bp_ch_held", int'(evt_ch), 1);
    end
    check_eq("bp_overrun_set", int'(overrun), 2);
    expect_evt(1, 0);
    expect_evt(1, 1);
    evt_ready = 1'b1;
    step(4);
    check_eq("bp_drain", exp_q.size(), 0);
    check_eq("bp_overrun_sticky", int'(overrun), 2);
    overrun_clr = 1'b1;
    step(1);
    overrun_clr = 1'b0;
    check_eq("bp_overrun_clr", int'(overrun), 0);

    // Period 0 fires every tick
    do_reset();
    set_period(3, 0);
    ch_en = 4'b1000;
    evt_ready = 1'b1;
    step(1);
    for (int t = 0; t < 3; t++) begin
      expect_evt(3, 2);
      do_tick();
      step(3);
    end
    step(2);
    check_eq("p0_drain", exp_q.size(), 0);

    // Period shortened from 10 to 2 at count 5
    do_reset();
    set_period(1, 10);
    ch_en = 4'b0010;
    evt_ready = 1'b1;
    step(1);
    for (int t = 1; t <= 5; t++) begin
      do_tick();
      step(3);
    end
    set_period(1, 2);
    for (int t = 6; t <= 10; t++) begin
      if (t == 6 || t == 8 || t == 10) expect_evt(1, 2);
      do_tick();
      step(3);
    end
    step(2);
    check_eq("pchg_drain", exp_q.size(), 0);

    // Disable drops a pending channel behind a stalled output
    do_reset();
    set_period(0, 1);
    set_period(2, 1);
    ch_en = 4'b0101;
    step(1);
    do_tick();
    step(3);
    check_eq("dis_valid", int'(evt_valid), 1);
    check_eq("dis_ch0_first", int'(evt_ch), 0);
    ch_en = 4'b0001;
    step(1);
    expect_evt(0, 0);
    evt_ready = 1'b1;
    step(6);
    check_eq("dis_drain", exp_q.size(), 0);
    check_eq("dis_idle", int'(evt_valid), 0);

    // Reset while an event is presented and an overrun is flagged
    evt_ready = 1'b0;
    set_period(1, 1);
    ch_en = 4'b0010;
    step(1);
    for (int t = 0; t < 3; t++) begin
      do_tick();
      step(3);
    end
    check_eq("mrst_pre_valid", int'(evt_valid), 1);
    check_eq("mrst_pre_overrun", int'(overrun), 2);
    ch_en = '0;
    reset = 1'b1;
    step(1);
    check_eq("mrst_valid", int'(evt_valid), 0);
    check_eq("mrst_overrun", int'(overrun), 0);
    check_eq("mrst_ch", int'(evt_ch), 0);
    reset = 1'b0;

    // Grant and expiry on the same channel in the same cycle
    do_reset();
    set_period(0, 1);
    ch_en = 4'b0001;
    evt_ready = 1'b1;
    step(1);
    expect_evt(0, 2);
    expect_evt(0, 3);
    i_tick = 1'b1;
    step(2);
    i_tick = 1'b0;
    step(4);
    check_eq("coll_overrun", int'(overrun), 0);
    check_eq("coll_drain", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
